// File: rtl/axilite_pkg.sv
// Shared types and response codes for the AXI4-Lite scratch-RAM slave.
package axilite_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_WDATA,
      WAIT_WADDR,
      WRITE_RESP,
      READ_DATA
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/axilite_mem.sv
// Byte-strobed word memory: async clear, one strobed write port, one registered read port.
module axilite_mem
   import axilite_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned IDX_W      = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic [DATA_WIDTH/8-1:0]  wr_strb,
   input  logic                     rd_en,
   input  logic                     rd_zero,
   input  logic [IDX_W-1:0]         rd_idx,
   output logic [DATA_WIDTH-1:0]    rd_data
);

   localparam int unsigned STRB_W = DATA_WIDTH / BYTE_W;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage array; reset clears every byte so no partial write survives an abort.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         for (int l = 0; l < int'(STRB_W); l++) begin
            if (wr_strb[l]) begin
               mem[wr_idx][l*BYTE_W +: BYTE_W] <= wr_data[l*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Read register holds its value until the next read, giving a stable rdata.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= rd_zero ? '0 : mem[rd_idx];
      end
   end

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite slave with a single outstanding transaction in front of a small byte-strobed RAM.
module axi_lite_slave
   import axilite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned MEM_SIZE_BYTES = 64
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_aresetn,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   input  logic [DATA_WIDTH-1:0]    s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]  s_axi_wstrb,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   output logic [1:0]               s_axi_bresp,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   output logic [DATA_WIDTH-1:0]    s_axi_rdata,
   output logic [1:0]               s_axi_rresp
);

   localparam int unsigned STRB_W = DATA_WIDTH / BYTE_W;
   localparam int unsigned DEPTH  = MEM_SIZE_BYTES / STRB_W;
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t CS, NS;

   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;

   logic                  aw_hs, w_hs, ar_hs;
   logic                  wr_commit, wr_in_range, rd_in_range;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;

   // Readies follow the state; reads are only offered when no write is being presented.
   assign s_axi_awready = s_axi_aresetn && (CS == IDLE || CS == WAIT_WADDR);
   assign s_axi_wready  = s_axi_aresetn && (CS == IDLE || CS == WAIT_WDATA);
   assign s_axi_arready = s_axi_aresetn && (CS == IDLE) && !s_axi_awvalid && !s_axi_wvalid;

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid  && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   // Whichever half arrived first comes from its latch, the other straight from the bus.
   assign wr_addr = (CS == WAIT_WDATA) ? aw_addr_q : s_axi_awaddr;
   assign wr_data = (CS == WAIT_WADDR) ? w_data_q  : s_axi_wdata;
   assign wr_strb = (CS == WAIT_WADDR) ? w_strb_q  : s_axi_wstrb;

   assign wr_commit = (CS == IDLE       && aw_hs && w_hs) ||
                      (CS == WAIT_WDATA && w_hs)          ||
                      (CS == WAIT_WADDR && aw_hs);

   assign wr_in_range = wr_addr      < ADDR_WIDTH'(MEM_SIZE_BYTES);
   assign rd_in_range = s_axi_araddr < ADDR_WIDTH'(MEM_SIZE_BYTES);

   always_comb begin
      NS = CS;
      case (CS)
         IDLE: begin
            if (aw_hs && w_hs)   NS = WRITE_RESP;
            else if (aw_hs)      NS = WAIT_WDATA;
            else if (w_hs)       NS = WAIT_WADDR;
            else if (ar_hs)      NS = READ_DATA;
         end
         WAIT_WDATA: if (w_hs)  NS = WRITE_RESP;
         WAIT_WADDR: if (aw_hs) NS = WRITE_RESP;
         WRITE_RESP: if (s_axi_bvalid && s_axi_bready) NS = IDLE;
         READ_DATA:  if (s_axi_rvalid && s_axi_rready) NS = IDLE;
         default:    NS = IDLE;
      endcase
   end

   // State, channel latches and response registers.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         CS           <= IDLE;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         s_axi_rvalid <= 1'b0;
         s_axi_rresp  <= RESP_OKAY;
      end else begin
         CS <= NS;
         if (CS == IDLE && aw_hs) begin
            aw_addr_q <= s_axi_awaddr;
         end
         if (CS == IDLE && w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end
         if (wr_commit) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end
         if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
         end
      end
   end

   axilite_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_mem (
      .clk     (s_axi_aclk),
      .rstn    (s_axi_aresetn),
      .wr_en   (wr_commit && wr_in_range),
      .wr_idx  (wr_addr[IDX_W+1:2]),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .rd_en   (ar_hs),
      .rd_zero (!rd_in_range),
      .rd_idx  (s_axi_araddr[IDX_W+1:2]),
      .rd_data (s_axi_rdata)
   );

endmodule

// File: tb/tb_axi_lite_slave.sv
// Randomized bench for axi_lite_slave against a byte-array memory model.
module tb_axi_lite_slave;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned MEM = 64;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   logic          clk, rst_n;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [7:0]  model_mem [MEM];

   axi_lite_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE_BYTES(MEM)) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_awaddr  (awaddr),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_bresp   (bresp),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_araddr  (araddr),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int unsigned b;
      if (a >= MEM) return 32'h0;
      b = a & 32'hFFFF_FFFC;
      return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int unsigned b;
      if (a >= MEM) return;
      b = a & 32'hFFFF_FFFC;
      for (int i = 0; i < 4; i++) begin
         if (s[i]) model_mem[b+i] = d[8*i +: 8];
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < int'(MEM); i++) model_mem[i] = 8'h00;
   endfunction

   task automatic idle_inputs();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready  = 1'b0; rready = 1'b0;
      awaddr  = '0; araddr = '0; wdata = '0; wstrb = '0;
   endtask

   // AW and W are offered independently after their own delays; optionally leaves the response pending.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int hold, input bit finish_b);
      bit aw_done = 0, w_done = 0, aw_fire, w_fire;
      int cyc = 0;
      logic [1:0] exp_resp;
      exp_resp = (a < MEM) ? OKAY : SLVERR;
      while (!(aw_done && w_done) && cyc < 40) begin
         @(negedge clk);
         if (aw_done != w_done) begin
            check("wait_awready", {63'd0, awready}, {63'd0, !aw_done});
            check("wait_wready",  {63'd0, wready},  {63'd0, !w_done});
            check("wait_bvalid",  {63'd0, bvalid},  64'd0);
         end
         awvalid = !aw_done && (cyc >= aw_dly);
         wvalid  = !w_done  && (cyc >= w_dly);
         awaddr  = a; wdata = d; wstrb = s;
         #1;
         aw_fire = awvalid && awready;
         w_fire  = wvalid  && wready;
         @(posedge clk);
         aw_done = aw_done || aw_fire;
         w_done  = w_done  || w_fire;
         cyc++;
      end
      check("write_handshake", {63'd0, aw_done && w_done}, 64'd1);
      model_write(a, d, s);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("bvalid_latency", {63'd0, bvalid}, 64'd1);
      check("bresp", {62'd0, bresp}, {62'd0, exp_resp});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("bvalid_hold", {63'd0, bvalid}, 64'd1);
         check("bresp_hold", {62'd0, bresp}, {62'd0, exp_resp});
      end
      if (finish_b) begin
         bready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bready = 1'b0;
         check("bvalid_clear", {63'd0, bvalid}, 64'd0);
      end
   endtask

   task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] data_out);
      bit ar_done = 0;
      int cyc = 0;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      exp_data = model_read(a);
      exp_resp = (a < MEM) ? OKAY : SLVERR;
      while (!ar_done && cyc < 40) begin
         @(negedge clk);
         arvalid = 1'b1; araddr = a;
         #1;
         ar_done = arready;
         @(posedge clk);
         cyc++;
      end
      check("read_handshake", {63'd0, ar_done}, 64'd1);
      @(negedge clk);
      arvalid = 1'b0;
      check("rvalid_latency", {63'd0, rvalid}, 64'd1);
      check("rdata", {32'd0, rdata}, {32'd0, exp_data});
      check("rresp", {62'd0, rresp}, {62'd0, exp_resp});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("rvalid_hold", {63'd0, rvalid}, 64'd1);
         check("rdata_hold", {32'd0, rdata}, {32'd0, exp_data});
      end
      data_out = rdata;
      rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rready = 1'b0;
      check("rvalid_clear", {63'd0, rvalid}, 64'd0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      model_clear();
      repeat (2) @(negedge clk);
      awvalid = 1'b1; wvalid = 1'b1;
      #1;
      check("rst_awready", {63'd0, awready}, 64'd0);
      check("rst_wready",  {63'd0, wready},  64'd0);
      check("rst_bvalid",  {63'd0, bvalid},  64'd0);
      check("rst_rvalid",  {63'd0, rvalid},  64'd0);
      check("rst_rdata",   {32'd0, rdata},   64'd0);
      check("rst_bresp",   {62'd0, bresp},   64'd0);
      check("rst_rresp",   {62'd0, rresp},   64'd0);
      awvalid = 1'b0; wvalid = 1'b0;
      #1;
      check("rst_arready", {63'd0, arready}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd, a, d;
      logic [3:0]  s;
      apply_reset();

      do_write(32'h0, 32'hAAAA_AAAA, 4'b0001, 0, 0, 0, 1);
      do_read(32'h0, 0, rd);
      check("dir_strb0001", {32'd0, rd}, 64'h0000_00AA);
      do_write(32'h4, 32'hAAAA_AAAA, 4'b0010, 0, 0, 0, 1);
      do_read(32'h4, 0, rd);
      check("dir_strb0010", {32'd0, rd}, 64'h0000_AA00);
      do_write(32'h8, 32'hAAAA_AAAA, 4'b0011, 0, 0, 0, 1);
      do_read(32'h8, 0, rd);
      check("dir_strb0011", {32'd0, rd}, 64'h0000_AAAA);
      do_write(32'h12, 32'hAAAA_AAAA, 4'b0100, 0, 0, 0, 1);
      do_read(32'h10, 0, rd);
      check("dir_unaligned", {32'd0, rd}, 64'h00AA_0000);

      // AW ahead of W, then W ahead of AW
      do_write(32'h20, 32'h1234_5678, 4'b1111, 0, 2, 0, 1);
      do_read(32'h20, 0, rd);
      check("dir_aw_first", {32'd0, rd}, 64'h1234_5678);
      do_write(32'h24, 32'h9ABC_DEF0, 4'b1111, 3, 0, 0, 1);
      do_read(32'h24, 0, rd);
      check("dir_w_first", {32'd0, rd}, 64'h9ABC_DEF0);

      // Back-pressure on both response channels
      do_write(32'h28, 32'hCAFE_F00D, 4'b1111, 0, 0, 5, 1);
      do_read(32'h28, 5, rd);

      // Simultaneous AR and AW/W: the write wins
      @(negedge clk);
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      awaddr = 32'h2C; wdata = 32'h5555_0001; wstrb = 4'b1111; araddr = 32'h2C;
      #1;
      check("prio_arready", {63'd0, arready}, 64'd0);
      @(posedge clk);
      model_write(32'h2C, 32'h5555_0001, 4'b1111);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("prio_bvalid", {63'd0, bvalid}, 64'd1);
      check("prio_rvalid", {63'd0, rvalid}, 64'd0);
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
      arvalid = 1'b0;
      do_read(32'h2C, 0, rd);
      check("prio_read_new", {32'd0, rd}, 64'h5555_0001);

      // Out-of-range accesses
      do_write(32'h40, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, 1);
      do_read(32'h40, 0, rd);
      check("oor_rdata", {32'd0, rd}, 64'd0);
      do_read(32'h0, 0, rd);
      check("oor_mem_intact", {32'd0, rd}, 64'h0000_00AA);

      // Reset while a write response is pending
      do_write(32'h30, 32'h0BAD_0BAD, 4'b1111, 0, 0, 0, 0);
      rst_n = 1'b0;
      model_clear();
      #1;
      check("midrst_bvalid", {63'd0, bvalid}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_idle_aw", {63'd0, awready}, 64'd1);
      check("midrst_idle_ar", {63'd0, arready}, 64'd1);
      do_read(32'h30, 0, rd);
      check("midrst_cleared", {32'd0, rd}, 64'd0);

      // Randomized mix checked against the byte model
      for (int n = 0; n < 200; n++) begin
         a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 79));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1)
            do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1);
         else
            do_read(a, $urandom_range(0, 2), rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
